// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM states, op encodings and sizing helper for the iterative mult/div unit
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;
  function automatic int cnt_w(input int width, input int spc);
    return $clog2(width / spc) + 1;
  endfunction
endpackage

// File: rtl/multdiv_step.sv
// multdiv_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) step
module multdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  input  logic             div,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic           ge;
  // multiply: add multiplicand when lo[0] set, shift {carry,hi,lo} right; divide: shift {hi,lo} left, subtract if it fits
  always_comb begin
    sum  = {1'b0, hi} + {1'b0, b & {WIDTH{lo[0]}}};
    sh   = {hi, lo[WIDTH-1]};
    ge   = sh >= {1'b0, b};
    hi_n = div ? (ge ? WIDTH'(sh - {1'b0, b}) : sh[WIDTH-1:0]) : sum[WIDTH:1];
    lo_n = div ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/iter_multdiv_unit.sv
// iter_multdiv_unit: iterative signed/unsigned multiply/divide with valid/ready, tag and flush
module iter_multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1,
  parameter int TAG_W           = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_mult,
  input  logic             op_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAG_W-1:0] out_tag
);
  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = cnt_w(WIDTH, STEPS_PER_CYCLE);
  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [1:0]         op, op_q;
  logic               sgn_q, neg_q, ovf_q;
  logic [WIDTH-1:0]   hi, lo, bq;
  logic [WIDTH-1:0]   hi_c [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0]   lo_c [STEPS_PER_CYCLE+1];
  logic               accept, early, mexc;
  logic [WIDTH-1:0]   mag_a, mag_b, q;
  logic [2*WIDTH-1:0] pf;

  assign op        = {op_div, op_mult};
  assign in_ready  = ~flush & (state == IDLE | state == DONE & out_ready);
  assign out_valid = state == DONE;
  assign accept    = in_valid & in_ready & (op != OP_NONE);
  assign early     = op == OP_ILL | op == OP_DIV & operand_b == '0;
  assign mag_a     = is_signed & operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b     = is_signed & operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign pf        = neg_q ? -{hi, lo} : {hi, lo};
  assign q         = neg_q ? -lo : lo;
  assign mexc      = sgn_q ? ~(&pf[2*WIDTH-1:WIDTH-1] | ~|pf[2*WIDTH-1:WIDTH-1]) : |hi;

  assign hi_c[0] = hi;
  assign lo_c[0] = lo;
  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    multdiv_step #(.WIDTH(WIDTH)) u_step (
      .hi  (hi_c[i]),
      .lo  (lo_c[i]),
      .b   (bq),
      .div (op_q == OP_DIV),
      .hi_n(hi_c[i+1]),
      .lo_n(lo_c[i+1])
    );
  end

  // next state: flush wins, accepts start a new op, RUN counts down into FIX, DONE holds until consumed
  always_comb begin
    state_n = flush ? IDLE :
              accept ? (early ? DONE : RUN) :
              state == RUN ? (cnt == CW'(1) ? FIX : RUN) :
              state == FIX ? DONE :
              state == DONE & ~out_ready ? DONE : IDLE;
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // datapath: latch magnitudes on accept, iterate in RUN, sign-correct and flag exceptions in FIX
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      op_q      <= OP_NONE;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      bq        <= '0;
      result    <= '0;
      exception <= 1'b0;
      out_tag   <= '0;
    end else if (accept) begin
      out_tag <= in_tag;
      if (early) begin
        result    <= '0;
        exception <= 1'b1;
        cnt       <= '0;
      end else begin
        cnt   <= CW'(N);
        op_q  <= op;
        sgn_q <= is_signed;
        neg_q <= is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        ovf_q <= op == OP_DIV & is_signed & operand_a == {1'b1, {(WIDTH-1){1'b0}}} & operand_b == '1;
        hi    <= '0;
        lo    <= op == OP_MULT ? mag_b : mag_a;
        bq    <= op == OP_MULT ? mag_a : mag_b;
      end
    end else if (state == RUN) begin
      hi  <= hi_c[STEPS_PER_CYCLE];
      lo  <= lo_c[STEPS_PER_CYCLE];
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      result    <= op_q == OP_MULT ? pf[WIDTH-1:0] : q;
      exception <= op_q == OP_MULT ? mexc : ovf_q;
    end
  end
endmodule

// File: doc/iter_multdiv_unit.md
Name: iter_multdiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the pipelined core's execute stage.
- Operates on WIDTH-bit operands in signed or unsigned mode.
- Retires STEPS_PER_CYCLE bits per clock.
- Uses a valid/ready handshake on both sides, carries a destination tag, and supports pipeline flush so branch recovery can kill an in-flight operation.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even).
- STEPS_PER_CYCLE, 1, quotient/multiplier bits processed per clock; must divide WIDTH.
- TAG_W, 5, width of destination tag carried with the operation (register index).

Ports:
- clock  in  1  master clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept this cycle
- op_mult  in  1  request is multiply
- op_div  in  1  request is divide
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned
- operand_a  in  WIDTH  multiplicand / dividend
- operand_b  in  WIDTH  multiplier / divisor
- in_tag  in  TAG_W  destination tag
- flush  in  1  kill in-flight or pending op
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  product low half / quotient
- exception  out  1  overflow, divide-by-zero, or illegal op
- out_tag  out  TAG_W  tag of the completed op

Behaviour:
- Clocking: one clock; reset is synchronous and active-high on port reset, sampled at the rising edge of clock.
- Reset state: state=IDLE; in_ready=1; out_valid=0; result=0; exception=0; out_tag=0; counter=0.
- FSM states: IDLE, RUN, FIX, DONE.
- Accept condition: in_valid & in_ready & (op_mult | op_div).
  - in_valid with neither op bit set is ignored: no transfer, state unchanged.
- in_ready = ~flush & (IDLE | (DONE & out_ready)). A new op can be accepted in the same cycle the previous result is consumed.
- On accept, latch operands, op, sign mode and tag:
  - Signed mode: store operand magnitudes plus result sign (a_sign XOR b_sign).
  - Divide overflow flag: set when is_signed, a = MIN and b = −1.
- Transitions out of accept:
  - Normal case: go to RUN with counter = WIDTH/STEPS_PER_CYCLE.
  - Early-out cases go directly to DONE, so out_valid is high the cycle after accept:
    - op_mult & op_div both set → result 0, exception 1.
    - op_div with operand_b = 0 → result 0, exception 1.
- RUN:
  - Each clock performs STEPS_PER_CYCLE shift-add (mult) or restoring shift-subtract (div) steps and decrements the counter.
  - When counter reaches 0, go to FIX.
- FIX: apply sign correction (negate if result sign set), compute exception, then go to DONE.
- Latency from accept edge to out_valid = WIDTH/STEPS_PER_CYCLE + 1 cycles (33 at defaults).
- Multiply rules:
  - result = low WIDTH bits of the 2·WIDTH product.
  - Signed: exception = 1 iff the product does not fit in WIDTH signed bits (upper WIDTH+1 bits not all equal).
  - Unsigned: exception = 1 iff the upper WIDTH bits are nonzero.
- Divide rules:
  - Quotient truncates toward zero; remainder is discarded.
  - Signed MIN/−1 → result = MIN, exception = 1, full latency.
- DONE:
  - result, exception and out_tag are held stable while out_valid=1 & out_ready=0.
  - out_ready=1 → IDLE, or back to RUN/DONE if a new op is accepted in the same cycle.
- Flush (highest priority below reset): next cycle state=IDLE, out_valid=0, and any in-flight or pending result is dropped. in_ready=0 in the flush cycle, so no accept can occur then.
- Reset mid-operation: identical to the reset state; no result is emitted.

Decomposition:
- Package multdiv_pkg: FSM state enum (IDLE, RUN, FIX, DONE), op-encoding localparams, and a function for counter width = $clog2(WIDTH/STEPS_PER_CYCLE)+1.
- Sub-module multdiv_step: combinational single-bit step covering both the add-shift and subtract-shift variants. It is instantiated STEPS_PER_CYCLE times in a generate chain. The FSM, counter and registers stay in the top module.

Test Plan:
1. Signed mult: a=−3 (0xFFFFFFFD), b=7, tag=5 → out_valid exactly 33 cycles after accept; result=0xFFFFFFEB, exception=0, out_tag=5.
2. Mult overflow: signed a=0x00010000, b=0x00010000 → result=0x00000000, exception=1. Unsigned a=0xFFFFFFFF, b=1 → result=0xFFFFFFFF, exception=0.
3. Divide: signed 0xFFFFFFF9/2 → 0xFFFFFFFD; unsigned 0xFFFFFFF9/2 → 0x7FFFFFFC. Signed 0x80000000/0xFFFFFFFF → 0x80000000, exception=1.
4. Divide by zero: 5/0 → out_valid 1 cycle after accept, result=0, exception=1. op_mult=op_div=1 → same response.
5. Backpressure and back-to-back:
   - Hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0.
   - Raise out_ready with in_valid=1 carrying a new op → in_ready=1 that cycle; the new result arrives 33 cycles later.
6. Flush at RUN cycle 10 → out_valid never rises for that op and in_ready=1 next cycle. Assert reset during RUN → all outputs at reset values next cycle.
